// File: rtl/cnn_pkg.sv
// cnn_pkg: shared frame-state type and counter width helper for the CNN window datapath
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
  function automatic int cw(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: frame control, source stream, line-buffer feed and window handshake
interface conv_window_ctrl_if #(parameter int DATA_W = 8, parameter int IMG_W = 4, parameter int IMG_H = 4);
  import cnn_pkg::*;
  localparam int RW = cw(IMG_H);
  localparam int CW = cw(IMG_W);
  logic start, busy, done;
  logic s_valid, s_ready;
  logic signed [DATA_W-1:0] s_pixel, lb_pixel;
  logic lb_clr, lb_in_valid;
  logic win_valid, win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  modport master (
    input start, s_valid, s_pixel, win_ready,
    output busy, done, s_ready, lb_clr, lb_in_valid, lb_pixel, win_valid, win_row, win_col
  );
  modport slave (
    output start, s_valid, s_pixel, win_ready,
    input busy, done, s_ready, lb_clr, lb_in_valid, lb_pixel, win_valid, win_row, win_col
  );
endinterface

// File: rtl/conv_window_ctrl_raster_counter.sv
// raster_counter: raster-order row/column position of the next pixel, with end-of-frame flag
module raster_counter import cnn_pkg::*; #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  parameter int RW = cw(IMG_H),
  parameter int CW = cw(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic col_end;
  assign col_end = col_q == CW'(IMG_W - 1);
  assign last = col_end && row_q == RW'(IMG_H - 1);
  assign row = row_q;
  assign col = col_q;
  // step one position per accepted pixel; column wraps at row end, both wrap after the last pixel
  always_comb begin
    row_d = clr || (inc && last) ? '0 : inc && col_end ? row_q + RW'(1) : row_q;
    col_d = clr || (inc && col_end) ? '0 : inc ? col_q + CW'(1) : col_q;
  end
  // position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frame sequencer qualifying strided 3x3 windows from a raster pixel stream
module conv_window_ctrl import cnn_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int STRIDE = 1
) (
  input logic clk,
  input logic rst,
  conv_window_ctrl_if.master io
);
  localparam int RW = cw(IMG_H);
  localparam int CW = cw(IMG_W);
  state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d, row, rm;
  logic [CW-1:0] win_col_q, win_col_d, col, cm;
  logic signed [DATA_W-1:0] pix;
  logic go, accept, last, qual, hs;
  assign go = state_q == IDLE && io.start;
  assign hs = win_valid_q && io.win_ready;
  // a pending window blocks the source so the line buffer cannot shift under it
  assign io.s_ready = state_q == RUN && (!win_valid_q || io.win_ready);
  assign accept = io.s_valid && io.s_ready;
  assign pix = io.s_pixel;
  assign io.lb_pixel = pix;
  assign io.lb_in_valid = accept;
  assign io.lb_clr = go;
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.win_valid = win_valid_q;
  assign io.win_row = win_row_q;
  assign io.win_col = win_col_q;
  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk(clk), .rst(rst), .clr(go), .inc(accept), .row(row), .col(col), .last(last)
  );
  // the window's bottom-right pixel must sit on the stride grid starting at (2,2)
  assign rm = row - RW'(2);
  assign cm = col - CW'(2);
  assign qual = row >= RW'(2) && col >= CW'(2) && rm % RW'(STRIDE) == '0 && cm % CW'(STRIDE) == '0;
  // frame sequencing and window hold/replace; a same-cycle qualifying accept overrides the handshake clear
  always_comb begin
    state_d = go ? RUN
            : accept && last ? FLUSH
            : state_q == FLUSH && (!win_valid_q || io.win_ready) ? DONE
            : state_q == DONE ? IDLE
            : state_q;
    win_valid_d = (accept && qual) || (win_valid_q && !hs);
    win_row_d = accept && qual ? rm / RW'(STRIDE) : win_row_q;
    win_col_d = accept && qual ? cm / CW'(STRIDE) : win_col_q;
    busy_d = state_d == RUN || state_d == FLUSH;
    done_d = state_d == DONE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      win_valid_q <= win_valid_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: table-driven frames with random gaps/backpressure checked against a spec-level window model
module tb_conv_window_ctrl;
  import cnn_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic sel = 1'b0, d_start = 1'b0, d_valid = 1'b0, d_ready = 1'b1;
  logic signed [7:0] d_pixel = '0;
  conv_window_ctrl_if #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) if4 ();
  conv_window_ctrl_if #(.DATA_W(8), .IMG_W(6), .IMG_H(6)) if6 ();
  assign if4.start = !sel && d_start;
  assign if4.s_valid = !sel && d_valid;
  assign if4.s_pixel = d_pixel;
  assign if4.win_ready = d_ready;
  assign if6.start = sel && d_start;
  assign if6.s_valid = sel && d_valid;
  assign if6.s_pixel = d_pixel;
  assign if6.win_ready = d_ready;
  conv_window_ctrl #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .STRIDE(1)) u4 (.clk(clk), .rst(rst), .io(if4));
  conv_window_ctrl #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .STRIDE(2)) u6 (.clk(clk), .rst(rst), .io(if6));
  logic m_sr, m_clr, m_lbv, m_busy, m_done, m_wv;
  logic [2:0] m_row, m_col;
  logic signed [7:0] m_pix;
  assign m_sr = sel ? if6.s_ready : if4.s_ready;
  assign m_clr = sel ? if6.lb_clr : if4.lb_clr;
  assign m_lbv = sel ? if6.lb_in_valid : if4.lb_in_valid;
  assign m_busy = sel ? if6.busy : if4.busy;
  assign m_done = sel ? if6.done : if4.done;
  assign m_wv = sel ? if6.win_valid : if4.win_valid;
  assign m_row = sel ? if6.win_row : {1'b0, if4.win_row};
  assign m_col = sel ? if6.win_col : {1'b0, if4.win_col};
  assign m_pix = sel ? if6.lb_pixel : if4.lb_pixel;

  typedef struct {int r, c, idx;} win_t;
  typedef struct {int sel, gap, bp, rdy, ign, nwin, first, last_, lat;} vec_t;
  int vec = 0, miss = 0, cyc = 0;
  int W = 4, H = 4, S = 1, N = 16;
  int done_n = 0, done_cyc = 0, last_cyc = 0, held = 0;
  bit running = 0, hold_prev = 0;
  logic [2:0] prow = '0, pcol = '0;
  logic signed [7:0] acc[$];
  win_t wins[$];

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [7:0] pix(input int i);
    return 8'(sel ? i + 1 : 10 * (i + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-cycle protocol checks and event recording, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      running = 0;
      hold_prev = 0;
    end else begin
      chk("lb_clr", m_clr, d_start && !running);
      chk("s_ready", m_sr, running && acc.size() < N && (!m_wv || d_ready));
      chk("lb_in_valid", m_lbv, d_valid && m_sr);
      if (m_lbv) chk("lb_pixel", m_pix, d_pixel);
      if (m_done) chk("busy_at_done", m_busy, 0);
      else chk("busy", m_busy, running);
      if (hold_prev) begin
        chk("hold_valid", m_wv, 1);
        chk("hold_row", m_row, prow);
        chk("hold_col", m_col, pcol);
      end
      if (m_wv && !d_ready) held++;
      hold_prev = m_wv && !d_ready;
      prow = m_row;
      pcol = m_col;
      if (m_wv && d_ready) wins.push_back('{int'(m_row), int'(m_col), acc.size() - 1});
      if (m_lbv) begin
        acc.push_back(m_pix);
        last_cyc = cyc;
      end
      if (m_done) begin
        done_n++;
        done_cyc = cyc;
        running = 0;
      end
      if (d_start && !running) running = 1;
    end
  end

  task automatic run_frame(input vec_t v);
    int t = 0;
    int bp_used = 0;
    int k = 0;
    sel = v.sel != 0;
    W = v.sel != 0 ? 6 : 4;
    H = W;
    S = v.sel != 0 ? 2 : 1;
    N = W * H;
    acc.delete();
    wins.delete();
    done_n = 0;
    held = 0;
    d_valid = v.ign != 0;
    d_pixel = pix(0);
    d_ready = 1'b1;
    repeat (v.ign != 0 ? 3 : 1) tick();
    d_start = 1'b1;
    tick();
    while (done_n == 0 && t < 3000) begin
      d_start = v.ign != 0 && acc.size() == 5;
      d_valid = acc.size() < N && $urandom_range(99) >= v.gap;
      d_pixel = pix(acc.size());
      d_ready = $urandom_range(99) < v.rdy;
      if (v.bp != 0 && bp_used < 5 && m_wv) begin
        d_ready = 1'b0;
        bp_used++;
      end
      tick();
      t++;
    end
    d_start = 1'b0;
    d_valid = 1'b0;
    d_ready = 1'b1;
    repeat (3) tick();
    chk("done_count", done_n, 1);
    if (v.lat >= 0) chk("done_latency", done_cyc - last_cyc, v.lat);
    if (v.bp != 0) chk("held_cycles", held, 5);
    else if (v.rdy == 100) chk("held_cycles", held, 0);
    chk("accepted", acc.size(), N);
    chk("win_count", wins.size(), v.nwin);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r >= 2 && c >= 2 && (r - 2) % S == 0 && (c - 2) % S == 0) begin
          if (k < wins.size()) begin
            chk("win_row", wins[k].r, (r - 2) / S);
            chk("win_col", wins[k].c, (c - 2) / S);
            chk("win_idx", wins[k].idx, r * W + c);
            if (r * W + c < acc.size()) begin
              chk("p22", acc[r * W + c], pix(r * W + c));
              chk("p00", acc[(r - 2) * W + c - 2], pix((r - 2) * W + c - 2));
            end
          end
          k++;
        end
    chk("model_win_count", wins.size(), k);
    if (wins.size() > 0) begin
      chk("first_win_idx", wins[0].idx, v.first);
      chk("last_win_idx", wins[wins.size() - 1].idx, v.last_);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int t = 0;
    tbl[0] = '{0, 0, 0, 100, 0, 4, 10, 15, 2};
    tbl[1] = '{1, 0, 0, 100, 0, 4, 14, 28, 2};
    tbl[2] = '{0, 35, 0, 100, 0, 4, 10, 15, 2};
    tbl[3] = '{0, 0, 1, 100, 0, 4, 10, 15, 2};
    tbl[4] = '{0, 0, 0, 100, 1, 4, 10, 15, 2};
    tbl[5] = '{1, 30, 0, 60, 0, 4, 14, 28, 2};
    tbl[6] = '{0, 30, 0, 60, 0, 4, 10, 15, -1};
    tbl[7] = '{1, 0, 1, 100, 1, 4, 14, 28, 2};
    repeat (3) tick();
    chk("rst_busy4", if4.busy, 0);
    chk("rst_done4", if4.done, 0);
    chk("rst_s_ready4", if4.s_ready, 0);
    chk("rst_lb_clr4", if4.lb_clr, 0);
    chk("rst_lb_in_valid4", if4.lb_in_valid, 0);
    chk("rst_win_valid4", if4.win_valid, 0);
    chk("rst_win_row4", if4.win_row, 0);
    chk("rst_win_col4", if4.win_col, 0);
    chk("rst_busy6", if6.busy, 0);
    chk("rst_win_valid6", if6.win_valid, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) run_frame(tbl[i]);
    sel = 1'b0;
    W = 4; H = 4; S = 1; N = 16;
    acc.delete();
    wins.delete();
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    d_valid = 1'b1;
    d_ready = 1'b1;
    while (acc.size() < 7 && t < 100) begin
      d_pixel = pix(acc.size());
      tick();
      t++;
    end
    chk("pre_rst_accepts", acc.size(), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", if4.busy, 0);
    chk("mid_rst_done", if4.done, 0);
    chk("mid_rst_s_ready", if4.s_ready, 0);
    chk("mid_rst_lb_clr", if4.lb_clr, 0);
    chk("mid_rst_lb_in_valid", if4.lb_in_valid, 0);
    chk("mid_rst_win_valid", if4.win_valid, 0);
    chk("mid_rst_win_row", if4.win_row, 0);
    chk("mid_rst_win_col", if4.win_col, 0);
    repeat (3) tick();
    chk("post_rst_no_accept", acc.size(), 7);
    d_valid = 1'b0;
    run_frame(tbl[0]);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
